craps_game_ctrl: RTL and testbench
==================================

Name: craps_game_ctrl

Overview:
- Game-sequencing FSM for the two-dice craps datapath.
- Converts the player's roll button into the datapath `roll` clock-enable.
- Waits for the registered dice/adder pipeline to settle, then samples the 4-bit dice sum.
- Applies craps rules (come-out roll, then point phase), drives the datapath `sp` point-latch strobe, and reports win/lose/point status to the board LEDs and HEX logic.

Parameters:
- SETTLE_CYCLES, 3: cycles after roll_en drops before sum is sampled (covers Num1To6 + Adder register depth); legal range 1..15.
- MIN_ROLL_CYCLES, 4: minimum cycles roll_en stays high per roll, even if the button is released earlier.
- DEBOUNCE_CYCLES, 16: stable-level cycles required by the optional debouncer.

Ports:
- clock: input, 1. System clock.
- reset: input, 1. Asynchronous, active-low reset.
- roll_btn: input, 1. Raw roll button, asynchronous, active-high.
- sum: input, 4. Dice sum from datapath adder; valid 2..12.
- roll_en: output, 1. Datapath `roll` clock-enable.
- sp: output, 1. One-cycle strobe; datapath latches sum as the point.
- point: output, 4. Controller copy of the current point; 0 when none.
- point_valid: output, 1. High while in the point phase.
- win: output, 1. Level; game won.
- lose: output, 1. Level; game lost.
- bad_sum: output, 1. One-cycle pulse; sampled sum was out of range.
- roll_count: output, 8. Rolls evaluated in the current game; saturates at 255.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. roll_en, sp, win, lose, bad_sum, point_valid = 0; point=0; roll_count=0; synchronizer flops = 0.
- roll_btn always passes through a 2-flop synchronizer. press = synced high AND previous synced low.
- States: IDLE, ROLLING, SETTLE, EVAL, POINT_WAIT, WIN, LOSE. Flag `comeout` = 1 in IDLE/WIN/LOSE entry, 0 once a point is set.
- IDLE, WIN, LOSE, POINT_WAIT: on press go to ROLLING and load the min-roll counter with MIN_ROLL_CYCLES.
  - From WIN or LOSE, a press first starts a new game in the same cycle: clear win, lose, point, point_valid, roll_count; set comeout=1.
- ROLLING: roll_en=1. Count down each cycle. Exit to SETTLE only when counter==0 AND synced button low. Load settle counter with SETTLE_CYCLES.
- SETTLE: roll_en=0. Count down; at 0 go to EVAL. Presses are ignored here.
- EVAL (one cycle): sample sum. roll_count++ (saturating) for an in-range sum only.
  - sum<2 or sum>12: pulse bad_sum; return to IDLE if comeout, else POINT_WAIT. No other change.
  - comeout, sum in {7,11}: go to WIN, win=1.
  - comeout, sum in {2,3,12}: go to LOSE, lose=1.
  - comeout, otherwise: sp=1 this cycle, point=sum, point_valid=1, comeout=0; go to POINT_WAIT.
  - point phase, sum==point: go to WIN, win=1.
  - point phase, sum==7: go to LOSE, lose=1.
  - point phase, otherwise: go to POINT_WAIT.
- sp is exactly one cycle wide, asserted only from EVAL, at most once per game.
- win and lose are mutually exclusive and hold until the next press or reset.
- Button held continuously through WIN/LOSE: no new press edge, so no new game until release and re-press.
- Reset mid-ROLLING drops roll_en asynchronously.
- Latency: button release (synced) to win/lose/sp = SETTLE_CYCLES + 1 cycles.

Optional Feature:
- Macro: CRAPS_DEBOUNCE_EN.
- Defined: the synchronized button feeds a counter-based debouncer. The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new level. press and release detection use the debounced level. This adds DEBOUNCE_CYCLES latency to both edges.
- Undefined: the debouncer is not instantiated; the synchronized level is used directly.
- The bench must pass in both builds (press/release intervals longer than DEBOUNCE_CYCLES+4).

Test Plan:
- Reset held low with roll_btn=1, then released with button low -> all outputs 0, state IDLE, roll_en=0.
- Button pulse of 1 cycle -> roll_en high exactly MIN_ROLL_CYCLES cycles. SETTLE_CYCLES+1 cycles after roll_en falls, EVAL runs; with sum=7, win=1, lose=0, roll_count=1.
- Come-out sum=6 -> sp one-cycle pulse, point=6, point_valid=1. Roll sum=8 -> no change, roll_count=2. Roll sum=6 -> win=1, roll_count=3.
- Come-out sum=4, then sum=7 -> lose=1, point stays 4. Next press -> point=0, point_valid=0, lose=0, roll_count=0, roll_en=1.
- Come-out sum=12 -> lose=1. Come-out sum=0 -> bad_sum single pulse, state IDLE, roll_count unchanged.
- Point phase, assert reset low mid-ROLLING -> roll_en=0 immediately; after release point=0, point_valid=0, win=lose=0.

Source files
------------

// File: rtl/craps_game_ctrl.sv
// Craps game sequencer: roll button -> roll_en, settle wait, sum evaluation, win/lose/point status.
// Define CRAPS_DEBOUNCE_EN to insert a counter debouncer after the button synchronizer.
module craps_game_ctrl #(
    parameter int SETTLE_CYCLES   = 3,
    parameter int MIN_ROLL_CYCLES = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       roll_btn,
    input  logic [3:0] sum,
    output logic       roll_en,
    output logic       sp,
    output logic [3:0] point,
    output logic       point_valid,
    output logic       win,
    output logic       lose,
    output logic       bad_sum,
    output logic [7:0] roll_count
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        IDLE, ROLLING, SETTLE, EVAL, POINT_WAIT, WIN, LOSE
    } state_t;

    state_t          state, state_nxt;
    logic            sync1, sync2, btn_lvl, btn_prev, press;
    logic [CW-1:0]   cnt;
    logic            comeout;
    logic            sum_ok, natural, craps, hit_point, seven;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= roll_btn;
            sync2 <= sync1;
        end
    end

`ifdef CRAPS_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DBW-1:0] db_cnt;
    logic           db_level;

    // Level flips only after DEBOUNCE_CYCLES consecutive cycles disagreeing with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync2 == db_level) begin
            db_cnt   <= '0;
        end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt   <= '0;
            db_level <= sync2;
        end else begin
            db_cnt   <= db_cnt + 1'b1;
        end
    end
    assign btn_lvl = db_level;
`else
    assign btn_lvl = sync2;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) btn_prev <= 1'b0;
        else        btn_prev <= btn_lvl;
    end
    assign press = btn_lvl & ~btn_prev;

    assign sum_ok    = (sum >= 4'd2) && (sum <= 4'd12);
    assign natural   = (sum == 4'd7) || (sum == 4'd11);
    assign craps     = (sum == 4'd2) || (sum == 4'd3) || (sum == 4'd12);
    assign hit_point = (sum == point);
    assign seven     = (sum == 4'd7);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, POINT_WAIT, WIN, LOSE: if (press) state_nxt = ROLLING;
            ROLLING: if (cnt <= CW'(1) && !btn_lvl) state_nxt = SETTLE;
            SETTLE:  if (cnt <= CW'(1)) state_nxt = EVAL;
            EVAL: begin
                if (!sum_ok)         state_nxt = comeout ? IDLE : POINT_WAIT;
                else if (comeout) begin
                    if (natural)     state_nxt = WIN;
                    else if (craps)  state_nxt = LOSE;
                    else             state_nxt = POINT_WAIT;
                end else begin
                    if (hit_point)   state_nxt = WIN;
                    else if (seven)  state_nxt = LOSE;
                    else             state_nxt = POINT_WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        roll_en = (state == ROLLING);
        sp      = (state == EVAL) && sum_ok && comeout && !natural && !craps;
        bad_sum = (state == EVAL) && !sum_ok;
    end

    // Counter holds its value for one cycle per count, so ROLLING/SETTLE last exactly the loaded count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (state != ROLLING && state_nxt == ROLLING)
            cnt <= CW'(MIN_ROLL_CYCLES);
        else if (state == ROLLING && state_nxt == SETTLE)
            cnt <= CW'(SETTLE_CYCLES);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            comeout     <= 1'b1;
            point       <= '0;
            point_valid <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
            roll_count  <= '0;
        end else if (press && (state == WIN || state == LOSE)) begin
            comeout     <= 1'b1;
            point       <= '0;
            point_valid <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
            roll_count  <= '0;
        end else if (state == EVAL && sum_ok) begin
            if (roll_count != 8'hFF) roll_count <= roll_count + 1'b1;
            if (comeout) begin
                if (natural)    win  <= 1'b1;
                else if (craps) lose <= 1'b1;
                else begin
                    point       <= sum;
                    point_valid <= 1'b1;
                    comeout     <= 1'b0;
                end
            end else if (hit_point) begin
                win     <= 1'b1;
                comeout <= 1'b1;
            end else if (seven) begin
                lose    <= 1'b1;
                comeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_craps_game_ctrl.sv
// Randomized self-checking bench for craps_game_ctrl against a rule-level game model.
module tb_craps_game_ctrl;

    localparam int SETTLE = 3;
    localparam int MINR   = 4;
    localparam int DEB    = 16;
`ifdef CRAPS_DEBOUNCE_EN
    localparam int HMIN = DEB + 5;
`else
    localparam int HMIN = 1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       roll_btn;
    logic [3:0] sum;
    logic       roll_en, sp, point_valid, win, lose, bad_sum;
    logic [3:0] point;
    logic [7:0] roll_count;

    int checks = 0;
    int fails  = 0;

    // Game model
    bit         m_comeout, m_pv, m_win, m_lose;
    logic [3:0] m_point;
    int         m_cnt;

    craps_game_ctrl #(
        .SETTLE_CYCLES(SETTLE), .MIN_ROLL_CYCLES(MINR), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock), .reset(reset), .roll_btn(roll_btn), .sum(sum),
        .roll_en(roll_en), .sp(sp), .point(point), .point_valid(point_valid),
        .win(win), .lose(lose), .bad_sum(bad_sum), .roll_count(roll_count)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_comeout = 1; m_pv = 0; m_win = 0; m_lose = 0; m_point = 0; m_cnt = 0;
    endtask

    // Drives one roll (button high for h cycles) and returns what was observed.
    task automatic do_roll(input logic [3:0] s, input int h,
                           output int ron, output logic [3:0] st_point, output logic st_pv,
                           output logic st_wl, output logic [7:0] st_cnt,
                           output logic sp_e, output logic bad_e,
                           output logic sp_n, output logic bad_n, output bit to);
        bit seen_hi;
        sum = s; ron = 0; seen_hi = 0; to = 1;
        sp_e = 0; bad_e = 0; sp_n = 0; bad_n = 0;
        st_point = 0; st_pv = 0; st_wl = 0; st_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clock); #1 roll_btn = (c < h);
            @(negedge clock);
            if (roll_en) begin
                if (!seen_hi) begin
                    st_point = point; st_pv = point_valid; st_wl = win | lose; st_cnt = roll_count;
                end
                ron++; seen_hi = 1;
            end else if (seen_hi) begin
                repeat (SETTLE) @(negedge clock);
                sp_e = sp; bad_e = bad_sum;
                @(negedge clock);
                sp_n = sp; bad_n = bad_sum;
                to = 0;
                break;
            end
        end
        roll_btn = 0;
    endtask

    task automatic test_reset();
        int hi;
        reset = 0; roll_btn = 1; sum = 4'd7;
        repeat (4) @(negedge clock);
        checks++;
        if ({roll_en, sp, win, lose, bad_sum, point_valid, point, roll_count} !== 18'd0) begin
            fails++; $display("FAIL reset_hold: outputs=%b want all zero",
                {roll_en, sp, win, lose, bad_sum, point_valid, point, roll_count});
        end
        roll_btn = 0;
        @(negedge clock); #2 reset = 1;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (roll_en) hi++;
        end
        checks++;
        if (hi != 0) begin fails++; $display("FAIL reset_idle_roll_en: high %0d cycles want 0", hi); end
        checks++;
        if ({sp, win, lose, bad_sum, point_valid, point, roll_count} !== 17'd0) begin
            fails++; $display("FAIL reset_release: outputs=%b want all zero",
                {sp, win, lose, bad_sum, point_valid, point, roll_count});
        end
        model_reset();
    endtask

    // Plays a list of rolls (directed or random) and checks each against the model.
    task automatic test_games(input string name, input bit rnd, input int n);
        logic [3:0] seq[$];
        logic [3:0] s, st_point;
        logic [7:0] st_cnt;
        logic       st_pv, st_wl, sp_e, bad_e, sp_n, bad_n;
        bit         to, exp_sp, exp_bad;
        int         h, ron, exp_ron;
        if (rnd) begin
            for (int i = 0; i < n; i++)
                seq.push_back(($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(2, 12)));
        end else begin
            seq = '{4'd7, 4'd6, 4'd8, 4'd6, 4'd4, 4'd7, 4'd12, 4'd0, 4'd5, 4'd15, 4'd5,
                    4'd11, 4'd3, 4'd2, 4'd9, 4'd10, 4'd9};
        end
        foreach (seq[i]) begin
            s = seq[i];
            h = (!rnd && i == 0) ? HMIN : HMIN + int'($urandom_range(0, 6));
            exp_ron = (h > MINR) ? h : MINR;
            if (m_win || m_lose) model_reset();
            exp_sp = 0; exp_bad = 0;
            do_roll(s, h, ron, st_point, st_pv, st_wl, st_cnt, sp_e, bad_e, sp_n, bad_n, to);
            checks++;
            if (to) begin
                fails++; $display("FAIL %s_timeout: roll %0d sum=%0d never finished", name, i, s);
                continue;
            end
            checks++;
            if (ron != exp_ron) begin fails++; $display("FAIL %s_roll_en_len: roll %0d got %0d want %0d", name, i, ron, exp_ron); end
            checks++;
            if (st_point !== m_point || st_pv !== m_pv || st_wl !== 1'b0 || st_cnt !== 8'(m_cnt)) begin
                fails++; $display("FAIL %s_roll_start: roll %0d point=%0d pv=%b wl=%b cnt=%0d want %0d %b 0 %0d",
                    name, i, st_point, st_pv, st_wl, st_cnt, m_point, m_pv, m_cnt);
            end
            // Rule-level evaluation of this roll
            if (s < 2 || s > 12) exp_bad = 1;
            else begin
                if (m_cnt < 255) m_cnt++;
                if (m_comeout) begin
                    if (s == 7 || s == 11) m_win = 1;
                    else if (s == 2 || s == 3 || s == 12) m_lose = 1;
                    else begin exp_sp = 1; m_point = s; m_pv = 1; m_comeout = 0; end
                end else if (s == m_point) m_win = 1;
                else if (s == 7) m_lose = 1;
            end
            checks++;
            if (sp_e !== exp_sp || sp_n !== 1'b0) begin
                fails++; $display("FAIL %s_sp: roll %0d sum=%0d sp=%b next=%b want %b 0", name, i, s, sp_e, sp_n, exp_sp);
            end
            checks++;
            if (bad_e !== exp_bad || bad_n !== 1'b0) begin
                fails++; $display("FAIL %s_bad_sum: roll %0d sum=%0d bad=%b next=%b want %b 0", name, i, s, bad_e, bad_n, exp_bad);
            end
            checks++;
            if (win !== m_win || lose !== m_lose) begin
                fails++; $display("FAIL %s_result: roll %0d sum=%0d win=%b lose=%b want %b %b", name, i, s, win, lose, m_win, m_lose);
            end
            checks++;
            if (point !== m_point || point_valid !== m_pv || roll_count !== 8'(m_cnt)) begin
                fails++; $display("FAIL %s_status: roll %0d point=%0d pv=%b cnt=%0d want %0d %b %0d",
                    name, i, point, point_valid, roll_count, m_point, m_pv, m_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_roll();
        logic [3:0] st_point;
        logic [7:0] st_cnt;
        logic       st_pv, st_wl, sp_e, bad_e, sp_n, bad_n;
        bit         to, up;
        int         ron;
        @(negedge clock); #2 reset = 0;
        @(negedge clock); #2 reset = 1;
        model_reset();
        do_roll(4'd8, HMIN, ron, st_point, st_pv, st_wl, st_cnt, sp_e, bad_e, sp_n, bad_n, to);
        checks++;
        if (to || point !== 4'd8 || point_valid !== 1'b1) begin
            fails++; $display("FAIL midroll_setup: to=%0d point=%0d pv=%b want 0 8 1", to, point, point_valid);
        end
        @(posedge clock); #1 roll_btn = 1;
        up = 0;
        for (int i = 0; i < 100 && !up; i++) begin
            @(negedge clock);
            up = roll_en;
        end
        checks++;
        if (!up) begin fails++; $display("FAIL midroll_start: roll_en=%b want 1", roll_en); end
        #2 reset = 0;
        #1;
        checks++;
        if (roll_en !== 1'b0) begin fails++; $display("FAIL midroll_async: roll_en=%b want 0", roll_en); end
        repeat (2) @(negedge clock);
        roll_btn = 0;
        @(negedge clock); #2 reset = 1;
        repeat (3) @(negedge clock);
        checks++;
        if ({roll_en, point, point_valid, win, lose, roll_count} !== 16'd0) begin
            fails++; $display("FAIL midroll_after: roll_en=%b point=%0d pv=%b win=%b lose=%b cnt=%0d want all 0",
                roll_en, point, point_valid, win, lose, roll_count);
        end
        model_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_games("directed", 1'b0, 0);
        test_games("random", 1'b1, 40);
        test_reset_mid_roll();
        test_games("after_reset", 1'b1, 10);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
